// File: rtl/accel_vec_pkg.sv
// Shared types and helpers for the vector-reduction engine (opcodes, FSM states, widths).
// Defining ACCEL_VEC_SAT_EN enables result clamping in accel_vec_engine.
package accel_vec_pkg;

  typedef enum logic [2:0] {
    OP_DOT = 3'd0,
    OP_L1  = 3'd1,
    OP_MIN = 3'd2,
    OP_MAX = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  // Wide enough that N full-scale products plus a full-scale bias never wrap.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/accel_vec_alu.sv
// Combinational per-beat reduction step: next accumulator from op, acc and one (a, b) pair.
// Zero latency; no handshake, the caller decides when the result is taken.
module accel_vec_alu
  import accel_vec_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 2 * W + 3
) (
  input  op_e                      op_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [W-1:0]      a_i,
  input  logic signed [W-1:0]      b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*W-1:0]   prod;
  logic [W:0]              diff;
  logic [W:0]              mag;
  logic signed [ACC_W-1:0] a_ext;

  always_comb begin
    prod  = a_i * b_i;
    // W+1 bits hold any difference of two W-bit signed values without wrap.
    diff  = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    mag   = diff[W] ? (~diff + (W+1)'(1)) : diff;
    a_ext = {{(ACC_W-W){a_i[W-1]}}, a_i};
    acc_o = acc_i;
    case (op_i)
      OP_DOT:  acc_o = acc_i + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
      OP_L1:   acc_o = acc_i + {{(ACC_W-W-1){1'b0}}, mag};
      OP_MIN:  acc_o = (a_ext < acc_i) ? a_ext : acc_i;
      OP_MAX:  acc_o = (a_ext > acc_i) ? a_ext : acc_i;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/accel_vec_engine.sv
// Command + N-beat streaming reducer; result valid 1 cycle after last beat, held until res_ready.
// in_ready only in RUN, cmd_ready only in IDLE; ACCEL_VEC_SAT_EN clamps the result to W bits.
module accel_vec_engine
  import accel_vec_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int ACC_W = acc_width(W, N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic signed [W-1:0]      cmd_bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W-1:0]      in_a,
  input  logic signed [W-1:0]      in_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     res_sat,
  output logic                     err,
  output logic                     busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic signed [ACC_W-1:0] ACC_POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_NEG_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] res_data_q, res_data_d;
  logic                    res_sat_q, res_sat_d;
  logic                    err_q, err_d;

  logic signed [ACC_W-1:0] alu_acc;
  logic signed [ACC_W-1:0] fin_data;
  logic                    fin_sat;
  logic signed [ACC_W-1:0] bias_ext;

  accel_vec_alu #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_alu (
    .op_i  (op_q),
    .acc_i (acc_q),
    .a_i   (in_a),
    .b_i   (in_b),
    .acc_o (alu_acc)
  );

  assign bias_ext = {{(ACC_W-W){cmd_bias[W-1]}}, cmd_bias};

`ifdef ACCEL_VEC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    fin_data = alu_acc;
    fin_sat  = 1'b0;
    if (alu_acc > SAT_MAX) begin
      fin_data = SAT_MAX;
      fin_sat  = 1'b1;
    end else if (alu_acc < SAT_MIN) begin
      fin_data = SAT_MIN;
      fin_sat  = 1'b1;
    end
  end
`else
  assign fin_data = alu_acc;
  assign fin_sat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_DOT;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_sat_q  <= res_sat_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    err_d      = 1'b0;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (is_legal_op(cmd_op)) begin
            op_d    = op_e'(cmd_op);
            cnt_d   = '0;
            state_d = RUN;
            // MIN/MAX start at the opposite extreme so the first beat always wins.
            case (op_e'(cmd_op))
              OP_MIN:  acc_d = ACC_POS_MAX;
              OP_MAX:  acc_d = ACC_NEG_MAX;
              default: acc_d = bias_ext;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = alu_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d    = DONE;
            res_data_d = fin_data;
            res_sat_d  = fin_sat;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
  assign err       = err_q;

endmodule

// File: doc/accel_vec_engine.md
Name: accel_vec_engine

Overview:
- Sequential, parametrised vector-reduction engine; successor to the fixed combinational dot2/dot4/MAC primitives in the accelerator.
- Accepts a command, opcode plus bias, then streams N element pairs (a_i, b_i) one per accepted beat.
- Produces one reduced result through a valid/ready output.
- Sits beside the accelerator top as a streaming compute unit.

Parameters:
- W, 16: element width; signed two's complement.
- N, 4: vector length in beats; must be ≥1.
- ACC_W, 2*W+$clog2(N)+1: accumulator and result width; derived, do not override.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  opcode: 0 DOT, 1 L1, 2 MIN, 3 MAX; 4-7 illegal.
- cmd_bias  in  W  signed bias; used by DOT and L1 only.
- in_valid  in  1  element pair offered.
- in_ready  out  1  engine accepts an element pair.
- in_a  in  W  signed element a_i.
- in_b  in  W  signed element b_i.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  ACC_W  signed result.
- res_sat  out  1  result was clamped; saturation build only, otherwise tied 0.
- err  out  1  one-cycle pulse on acceptance of an illegal opcode.
- busy  out  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE. acc, beat counter, res_data, res_sat and err are 0. res_valid=0. cmd_ready=1 in the first cycle after reset.
- IDLE: cmd_ready=1, in_ready=0, busy=0.
  - cmd_valid&cmd_ready with legal op: latch op; init acc. DOT/L1 init acc=sext(bias). MIN init acc=+max. MAX init acc=-max. Clear counter; go to RUN next cycle.
  - Illegal op: err=1 for exactly the next cycle; stay in IDLE; no result produced.
- RUN: in_ready=1, cmd_ready=0. Each in_valid&in_ready beat updates acc:
  - DOT: acc += a*b, full-precision signed product.
  - L1: acc += |a-b|, difference computed in W+1 bits.
  - MIN: acc = min(acc, a). b ignored.
  - MAX: acc = max(acc, a). b ignored.
  - Counter increments per beat. The N-th beat moves the FSM to DONE.
  - in_valid low: no update (bubbles allowed, any length).
- DONE: res_valid=1 and res_data=acc, registered. res_valid rises the cycle after the N-th beat, so latency is 1 cycle from the last beat.
  - res_data and res_sat stay stable while res_ready=0.
  - res_valid&res_ready: go to IDLE; cmd_ready=1 the next cycle. No zero-cycle turnaround.
- Inputs outside their phase: in_valid in IDLE/DONE and cmd_valid in RUN/DONE are ignored, with no side effects.
- Overflow: ACC_W sized so DOT/L1 cannot overflow for any inputs and bias. MIN/MAX results are sign-extended to ACC_W.
- Reset mid-operation: rst in any state returns to IDLE next cycle, all outputs at reset values, partial acc discarded.
- N=1: a single beat leads to DONE.

Optional Feature:
- Macro ACCEL_VEC_SAT_EN.
- Defined: at the RUN→DONE transition, res_data is clamped to the signed W range [-2^(W-1), 2^(W-1)-1] and sign-extended to ACC_W. res_sat=1 iff clamping occurred.
- Undefined: res_data is the full ACC_W accumulator and res_sat is constant 0.

Decomposition:
- Package accel_vec_pkg holds:
  - op_e enum (OP_DOT, OP_L1, OP_MIN, OP_MAX).
  - state_e enum (IDLE, RUN, DONE).
  - is_legal_op function.
  - acc_width(W,N) function used for ACC_W.
- One sub-module, accel_vec_alu: combinational; takes op, acc, a, b and returns next acc. Keeps the FSM/handshake module separate from the arithmetic.

Test Plan:
- DOT, bias=5, a=[12,2,3,4], b=[3,6,7,8], no bubbles → res_valid the cycle after beat 4, res_data=106, res_sat=0.
- L1, bias=0, a=[1,-2,3,4], b=[4,2,3,0], bubbles of 2 cycles between beats → res_data=11.
- MAX, a=[-5,7,-1,3] → 7. MIN with the same a → -5 (sign-extended). in_valid pulses in IDLE before the command → ignored.
- Illegal op=5 → err high exactly 1 cycle, no res_valid, cmd_ready=1 throughout. A following DOT command works normally.
- Backpressure: hold res_ready=0 for 3 cycles in DONE → res_data stable, cmd_ready=0, extra cmd_valid ignored. Release → IDLE next cycle.
- Saturation: DOT, a=b=[32767]x4, bias=0:
  - With ACCEL_VEC_SAT_EN → res_data=32767, res_sat=1.
  - Without it → res_data=4294705156, res_sat=0.
  - Also assert rst after 2 beats of any op → IDLE next cycle, res_valid=0, acc=0.
